// File: rtl/register_file_shadowed.sv
// register_file_shadowed: GR file, 2 async read ports, 1 write port, GR0 = 0, shadow bank save/restore
// Optional write-through forwarding on the read ports when RF_BYPASS_EN is defined.
module register_file_shadowed #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter logic [NUM_REGS-1:0] SHADOW_MASK = 32'h0303_0302
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [DATA_W-1:0]           PW,
  input  logic [$clog2(NUM_REGS)-1:0] RW,
  input  logic                        EN,
  input  logic [$clog2(NUM_REGS)-1:0] RA,
  input  logic [$clog2(NUM_REGS)-1:0] RB,
  output logic [DATA_W-1:0]           PA,
  output logic [DATA_W-1:0]           PB,
  input  logic                        SAVE,
  input  logic                        RESTORE,
  output logic                        SHADOW_VALID,
  output logic [NUM_REGS-1:0]         DECODER_OUT
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [DATA_W-1:0] gr_q [NUM_REGS];
  logic [DATA_W-1:0] gr_d [NUM_REGS];
  logic [DATA_W-1:0] sh_q [NUM_REGS];
  logic [DATA_W-1:0] sh_d [NUM_REGS];
  logic valid_q, valid_d;
  logic do_restore, do_save, wr_ok;
  assign do_restore = RESTORE && valid_q;
  assign do_save = SAVE && !RESTORE;
  assign wr_ok = EN && (RW != '0);
  assign SHADOW_VALID = valid_q;
  assign DECODER_OUT = wr_ok ? (NUM_REGS'(1) << RW) : '0;
  // next state: a valid restore wins over a write to a shadowed GR; save samples pre-edge GRs
  always_comb begin
    gr_d = gr_q;
    sh_d = sh_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      gr_d[i] = (SHADOW_MASK[i] && do_restore) ? sh_q[i] : (EN && RW == ADDR_W'(i)) ? PW : gr_q[i];
      sh_d[i] = (SHADOW_MASK[i] && do_save) ? gr_q[i] : sh_q[i];
    end
    valid_d = do_restore ? 1'b0 : do_save ? 1'b1 : valid_q;
  end
  // state registers, cleared immediately by RST_N
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gr_q <= '{default: '0};
      sh_q <= '{default: '0};
      valid_q <= 1'b0;
    end else begin
      gr_q <= gr_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
    end
  end
`ifdef RF_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = wr_ok && !(do_restore && SHADOW_MASK[RW]);
  // read ports with forwarding of the pending write unless a restore overrides it
  always_comb begin
    PA = (RA == '0) ? '0 : (fwd_ok && RA == RW) ? PW : gr_q[RA];
    PB = (RB == '0) ? '0 : (fwd_ok && RB == RW) ? PW : gr_q[RB];
  end
`else
  // read ports show the registered GR contents
  always_comb begin
    PA = (RA == '0) ? '0 : gr_q[RA];
    PB = (RB == '0) ? '0 : gr_q[RB];
  end
`endif
endmodule

// File: tb/tb_register_file_shadowed.sv
// tb_register_file_shadowed: randomized and directed checks against an array-based reference model
module tb_register_file_shadowed;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam logic [NR-1:0] MASK = 32'h0303_0302;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [DW-1:0] PW = '0;
  logic [AW-1:0] RW = '0, RA = '0, RB = '0;
  logic EN = 1'b0, SAVE = 1'b0, RESTORE = 1'b0;
  logic [DW-1:0] PA, PB;
  logic SHADOW_VALID;
  logic [NR-1:0] DECODER_OUT;
  logic [DW-1:0] mgr [NR];
  logic [DW-1:0] msh [NR];
  logic mvalid;
  int n_cmp = 0;
  int n_err = 0;

  register_file_shadowed #(.DATA_W(DW), .NUM_REGS(NR), .SHADOW_MASK(MASK)) dut (
    .CLK(CLK), .RST_N(RST_N), .PW(PW), .RW(RW), .EN(EN), .RA(RA), .RB(RB),
    .PA(PA), .PB(PB), .SAVE(SAVE), .RESTORE(RESTORE),
    .SHADOW_VALID(SHADOW_VALID), .DECODER_OUT(DECODER_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic bit shadowed(input int i);
    return i != 0 && MASK[i];
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (EN && RW != 0 && a == RW && !(RESTORE && mvalid && shadowed(int'(RW)))) return PW;
`endif
    return mgr[a];
  endfunction

  function automatic logic [NR-1:0] exp_dec();
    logic [NR-1:0] d = '0;
    if (EN && RW != 0) d[RW] = 1'b1;
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      mgr[i] = '0;
      msh[i] = '0;
    end
    mvalid = 1'b0;
  endtask

  task automatic set_in(input logic en, input logic [AW-1:0] rw, input logic [DW-1:0] pw,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic sv, input logic rs);
    EN = en; RW = rw; PW = pw; RA = ra; RB = rb; SAVE = sv; RESTORE = rs;
  endtask

  task automatic clock_edge();
    logic [DW-1:0] old [NR];
    bit do_r, do_s;
    old = mgr;
    do_r = RESTORE && mvalid;
    do_s = SAVE && !RESTORE;
    if (EN && RW != 0 && !(do_r && shadowed(int'(RW)))) mgr[RW] = PW;
    for (int i = 1; i < NR; i++) begin
      if (shadowed(i) && do_r) mgr[i] = msh[i];
      if (shadowed(i) && do_s) msh[i] = old[i];
    end
    if (do_r) mvalid = 1'b0;
    else if (do_s) mvalid = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] rw, input logic [DW-1:0] pw);
    set_in(1'b1, rw, pw, '0, '0, 1'b0, 1'b0);
    clock_edge();
    set_in(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    set_in(1'b0, '0, '0, 5'd5, 5'd0, 1'b0, 1'b0);
    @(posedge CLK); @(posedge CLK); #3;
    RST_N = 1'b1;
    model_clear();
    #1;
    n_cmp++; if (PA !== '0) begin n_err++; $display("FAIL reset_pa got=%h want=0", PA); end
    n_cmp++; if (SHADOW_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", SHADOW_VALID); end
    wr(5'd5, 32'h55);
    set_in(1'b0, '0, '0, 5'd5, 5'd0, 1'b1, 1'b0);
    clock_edge();
    SAVE = 1'b0;
    n_cmp++; if (PA !== 32'h55 || SHADOW_VALID !== 1'b1) begin n_err++; $display("FAIL pre_reset got=%h/%b want=55/1", PA, SHADOW_VALID); end
    #3;
    RST_N = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (PA !== '0) begin n_err++; $display("FAIL async_reset_pa got=%h want=0", PA); end
    n_cmp++; if (SHADOW_VALID !== 1'b0) begin n_err++; $display("FAIL async_reset_valid got=%b want=0", SHADOW_VALID); end
    set_in(1'b1, 5'd3, 32'h1234, 5'd3, 5'd5, 1'b1, 1'b0);
    @(posedge CLK); #1;
    n_cmp++; if (PA !== '0 || SHADOW_VALID !== 1'b0) begin n_err++; $display("FAIL reset_blocks got=%h/%b want=0/0", PA, SHADOW_VALID); end
    #2;
    RST_N = 1'b1;
    set_in(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge CLK); #1;
  endtask

  task automatic test_write_sweep();
    for (int k = 1; k < NR; k++) wr(AW'(k), DW'(19 + k));
    for (int k = 0; k < NR; k++) begin
      RA = AW'(k); RB = AW'(31 - k); #1;
      n_cmp++; if (PA !== ((k == 0) ? DW'(0) : DW'(19 + k))) begin n_err++; $display("FAIL sweep_pa ra=%0d got=%h want=%h", k, PA, (k == 0) ? 0 : 19 + k); end
      n_cmp++; if (PB !== ((k == 31) ? DW'(0) : DW'(50 - k))) begin n_err++; $display("FAIL sweep_pb rb=%0d got=%h want=%h", 31 - k, PB, (k == 31) ? 0 : 50 - k); end
    end
    for (int k = 1; k < NR; k++) begin
      set_in(1'b0, AW'(k), DW'(55 + k), AW'(k), AW'(k), 1'b0, 1'b0); #1;
      n_cmp++; if (DECODER_OUT !== '0) begin n_err++; $display("FAIL dec_en0 rw=%0d got=%h want=0", k, DECODER_OUT); end
      clock_edge();
      n_cmp++; if (PA !== DW'(19 + k) || PB !== DW'(19 + k)) begin n_err++; $display("FAIL en0_keep rw=%0d got=%h/%h want=%h", k, PA, PB, 19 + k); end
    end
  endtask

  task automatic test_gr0();
    set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    n_cmp++; if (DECODER_OUT !== '0) begin n_err++; $display("FAIL gr0_dec got=%h want=0", DECODER_OUT); end
    clock_edge();
    n_cmp++; if (PA !== '0 || PB !== '0) begin n_err++; $display("FAIL gr0_read got=%h/%h want=0", PA, PB); end
    set_in(1'b1, 5'd31, 32'h1, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    n_cmp++; if (DECODER_OUT !== 32'h8000_0000) begin n_err++; $display("FAIL dec_31 got=%h want=80000000", DECODER_OUT); end
    EN = 1'b0;
  endtask

  task automatic test_save_restore();
    wr(5'd1, 32'h11); wr(5'd8, 32'h88);
    set_in(1'b0, '0, '0, 5'd1, 5'd8, 1'b1, 1'b0); clock_edge(); SAVE = 1'b0;
    n_cmp++; if (SHADOW_VALID !== 1'b1) begin n_err++; $display("FAIL save_valid got=%b want=1", SHADOW_VALID); end
    wr(5'd1, 32'hAA); wr(5'd8, 32'hBB);
    RA = 5'd1; RB = 5'd8; #1;
    n_cmp++; if (PA !== 32'hAA || PB !== 32'hBB) begin n_err++; $display("FAIL overwrite got=%h/%h want=aa/bb", PA, PB); end
    RESTORE = 1'b1; clock_edge(); RESTORE = 1'b0;
    n_cmp++; if (PA !== 32'h11 || PB !== 32'h88 || SHADOW_VALID !== 1'b0) begin n_err++; $display("FAIL restore got=%h/%h/%b want=11/88/0", PA, PB, SHADOW_VALID); end
    wr(5'd1, 32'hCC);
    set_in(1'b0, '0, '0, 5'd1, 5'd8, 1'b0, 1'b1); clock_edge(); RESTORE = 1'b0;
    n_cmp++; if (PA !== 32'hCC || PB !== 32'h88 || SHADOW_VALID !== 1'b0) begin n_err++; $display("FAIL restore_again got=%h/%h/%b want=cc/88/0", PA, PB, SHADOW_VALID); end
    wr(5'd16, 32'h16);
    set_in(1'b1, 5'd16, 32'hDEAD, 5'd16, 5'd0, 1'b1, 1'b0); clock_edge();
    set_in(1'b0, '0, '0, 5'd16, 5'd0, 1'b0, 1'b1); clock_edge(); RESTORE = 1'b0;
    n_cmp++; if (PA !== 32'h16) begin n_err++; $display("FAIL save_pre_edge got=%h want=16", PA); end
  endtask

  task automatic test_collisions();
    wr(5'd9, 32'h5A);
    set_in(1'b0, '0, '0, 5'd9, 5'd0, 1'b1, 1'b0); clock_edge();
    wr(5'd9, 32'h77);
    set_in(1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 1'b1, 1'b1); #1;
    n_cmp++; if (PA !== 32'h77) begin n_err++; $display("FAIL bypass_suppressed got=%h want=77", PA); end
    clock_edge();
    n_cmp++; if (PA !== 32'h5A || SHADOW_VALID !== 1'b0) begin n_err++; $display("FAIL restore_beats got=%h/%b want=5a/0", PA, SHADOW_VALID); end
    set_in(1'b0, '0, '0, 5'd9, 5'd2, 1'b1, 1'b0); clock_edge();
    set_in(1'b1, 5'd2, 32'h22, 5'd9, 5'd2, 1'b0, 1'b1); clock_edge();
    n_cmp++; if (PB !== 32'h22 || PA !== 32'h5A || SHADOW_VALID !== 1'b0) begin n_err++; $display("FAIL parallel_write got=%h/%h/%b want=5a/22/0", PA, PB, SHADOW_VALID); end
    set_in(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    wr(5'd7, 32'h70);
    set_in(1'b1, 5'd7, 32'h77, 5'd7, 5'd7, 1'b0, 1'b0); #1;
`ifdef RF_BYPASS_EN
    n_cmp++; if (PA !== 32'h77 || PB !== 32'h77) begin n_err++; $display("FAIL bypass got=%h/%h want=77", PA, PB); end
`else
    n_cmp++; if (PA !== 32'h70 || PB !== 32'h70) begin n_err++; $display("FAIL no_bypass got=%h/%h want=70", PA, PB); end
`endif
    clock_edge();
    n_cmp++; if (PA !== 32'h77) begin n_err++; $display("FAIL bypass_after got=%h want=77", PA); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      set_in(1'($urandom), AW'($urandom), $urandom, AW'($urandom), AW'($urandom),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      #1;
      n_cmp++; if (PA !== exp_rd(RA)) begin n_err++; $display("FAIL rand_pa n=%0d got=%h want=%h", n, PA, exp_rd(RA)); end
      n_cmp++; if (PB !== exp_rd(RB)) begin n_err++; $display("FAIL rand_pb n=%0d got=%h want=%h", n, PB, exp_rd(RB)); end
      n_cmp++; if (DECODER_OUT !== exp_dec()) begin n_err++; $display("FAIL rand_dec n=%0d got=%h want=%h", n, DECODER_OUT, exp_dec()); end
      n_cmp++; if (SHADOW_VALID !== mvalid) begin n_err++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, SHADOW_VALID, mvalid); end
      clock_edge();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_sweep();
    test_gr0();
    test_save_restore();
    test_collisions();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/register_file_shadowed.md
Name: register_file_shadowed

Overview:
- Parametrised next-generation general register file for the PA-RISC datapath: 2 async read ports, 1 sync write port, GR0 hardwired to zero, asynchronous clear.
- Adds a shadow bank for the interruption-shadowed GRs (default GR1,8,9,16,17,24,25): single-cycle SAVE and RESTORE.
- Sits between the decode stage (reads) and the writeback stage (write).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of GRs; power of 2, >= 4; ADDR_W = $clog2(NUM_REGS) is derived locally.
- SHADOW_MASK, 32'h0303_0302, NUM_REGS-bit mask; bit i=1 means GRi is shadowed; bit 0 is ignored.

Ports:
- CLK  in  1  clock, rising edge active.
- RST_N  in  1  asynchronous active-low reset.
- PW  in  DATA_W  write data.
- RW  in  ADDR_W  write address.
- EN  in  1  write enable.
- RA  in  ADDR_W  read address, port A.
- RB  in  ADDR_W  read address, port B.
- PA  out  DATA_W  read data, port A.
- PB  out  DATA_W  read data, port B.
- SAVE  in  1  copy shadowed GRs into the shadow bank.
- RESTORE  in  1  copy the shadow bank back into the shadowed GRs.
- SHADOW_VALID  out  1  shadow bank holds a saved image.
- DECODER_OUT  out  NUM_REGS  one-hot write decode, for debug.

Behaviour:
- Reset: RST_N low clears immediately, without waiting for CLK, all GRs, all shadow entries and SHADOW_VALID. Write, save and restore are blocked while RST_N is low. A reset that lands between SAVE and RESTORE discards the image.
- Write: on posedge CLK with EN=1 and RW!=0, GR[RW] <= PW. A write to GR0 is discarded.
- Read: combinational.
  - PA = (RA==0) ? 0 : GR[RA]; PB likewise from RB.
  - RA==RB is legal; both ports return the same value.
- DECODER_OUT: combinational; bit RW = EN & (RW!=0), all other bits 0. Equals 0 when EN=0 or RW=0.
- SAVE: on posedge with SAVE=1 and RESTORE=0:
  - every shadowed GRi is copied to SH[i]; SHADOW_VALID <= 1.
  - SH captures the pre-edge GR value, even if the same edge writes that GR.
  - Repeating SAVE overwrites the image.
- RESTORE: on posedge with RESTORE=1 and SHADOW_VALID=1:
  - every shadowed GRi <= SH[i]; SHADOW_VALID <= 0.
  - RESTORE with SHADOW_VALID=0 is ignored and the GRs are unchanged.
- Priority on the same edge:
  - RESTORE beats SAVE; SAVE is dropped.
  - For a shadowed RW, a valid RESTORE beats EN; the PW value is lost.
  - A write to a non-shadowed RW proceeds in parallel with RESTORE.
- Latency: a write is visible on PA/PB the cycle after its edge; SAVE/RESTORE take effect at the edge.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding.
  - If EN=1, RW!=0 and RA==RW, then PA = PW in the same cycle, before the edge; same rule for PB with RB.
  - If a valid RESTORE is pending on that edge and RW is shadowed, the bypass is suppressed and PA/PB show the old GR.
- Undefined: no forwarding; PA/PB show the old GR value until the edge.

Test Plan:
- Reset with GR5=0x55: pulse RST_N low mid-cycle -> PA (RA=5)=0 immediately, SHADOW_VALID=0, with no clock edge needed.
- Write sweep, EN=1: RW=1..31 with PW=20..50, then read RA=k, RB=31-k -> PA=19+k, PB=50-k (GR0 reads 0). Repeat with EN=0 and PW=55.. -> contents unchanged, DECODER_OUT=0.
- GR0 write: RW=0, PW=0xFFFF_FFFF, EN=1 -> DECODER_OUT=0, PA (RA=0)=0.
- Save/restore:
  - GR1=0x11, GR8=0x88, SAVE pulse -> SHADOW_VALID=1.
  - Write GR1=0xAA, GR8=0xBB, then RESTORE -> GR1=0x11, GR8=0x88, SHADOW_VALID=0.
  - A second RESTORE -> no change.
- Collisions:
  - SAVE and RESTORE in the same cycle with a valid image -> restore performed, SHADOW_VALID=0.
  - RESTORE plus EN writing GR9=0x99 -> GR9 = shadow value.
  - RESTORE plus EN writing GR2=0x22 -> GR2=0x22.
- Bypass (RF_BYPASS_EN): EN=1, RW=RA=7, PW=0x77 -> PA=0x77 before the edge. Without the macro -> old GR7 until the edge.
